// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - interlock/forwarding controller tracking dest regs in stages EX..WB
module pipe_hazard_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NSTAGES    = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 32,
    localparam int SELW      = $clog2(NSTAGES + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [REG_ADDR_W-1:0]         id_src_a,
    input  logic                          id_src_a_used,
    input  logic [REG_ADDR_W-1:0]         id_src_b,
    input  logic                          id_src_b_used,
    input  logic [REG_ADDR_W-1:0]         id_dest,
    input  logic                          id_dest_valid,
    input  logic                          id_load,
    input  logic [DATA_WIDTH-1:0]         rf_data_a,
    input  logic [DATA_WIDTH-1:0]         rf_data_b,
    input  logic [NSTAGES*DATA_WIDTH-1:0] stage_result,
    input  logic                          mem_busy,
    input  logic                          ex_flush,
    output logic [DATA_WIDTH-1:0]         op_a,
    output logic [DATA_WIDTH-1:0]         op_b,
    output logic [SELW-1:0]               fwd_a_sel,
    output logic [SELW-1:0]               fwd_b_sel,
    output logic                          stall_if_id,
    output logic                          bubble_id_ex,
    output logic                          freeze,
    output logic                          flush_if_id,
    output logic [CNT_W-1:0]              stall_cycles
);

    // Entry s (1-based) lives at bit s-1 / slice [(s-1)*REG_ADDR_W +: REG_ADDR_W].
    logic [NSTAGES-1:0]            ent_v;
    logic [NSTAGES-1:0]            ent_load;
    logic [NSTAGES*REG_ADDR_W-1:0] ent_dest;

    logic [SELW-1:0] win_a;
    logic [SELW-1:0] win_b;
    logic            early_a;
    logic            early_b;
    logic            hazard;
    logic            new_v;

    // Walk from oldest to youngest so the lowest matching stage is the one left standing.
    always_comb begin
        win_a   = '0;
        win_b   = '0;
        early_a = 1'b0;
        early_b = 1'b0;
        for (int s = NSTAGES; s >= 1; s--) begin
            if (ent_v[s-1] && ent_dest[(s-1)*REG_ADDR_W +: REG_ADDR_W] == id_src_a
                    && id_src_a != '0) begin
                win_a   = SELW'(s);
                early_a = ent_load[s-1] && (s < LOAD_STAGE);
            end
            if (ent_v[s-1] && ent_dest[(s-1)*REG_ADDR_W +: REG_ADDR_W] == id_src_b
                    && id_src_b != '0) begin
                win_b   = SELW'(s);
                early_b = ent_load[s-1] && (s < LOAD_STAGE);
            end
        end
    end

    assign fwd_a_sel = id_src_a_used ? win_a : '0;
    assign fwd_b_sel = id_src_b_used ? win_b : '0;

    always_comb begin
        op_a = rf_data_a;
        op_b = rf_data_b;
        for (int s = 1; s <= NSTAGES; s++) begin
            if (fwd_a_sel == SELW'(s))
                op_a = stage_result[(s-1)*DATA_WIDTH +: DATA_WIDTH];
            if (fwd_b_sel == SELW'(s))
                op_b = stage_result[(s-1)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A load whose data is not ready yet can only be waited out, never forwarded.
    assign hazard = id_valid && ((id_src_a_used && early_a) || (id_src_b_used && early_b));

    assign freeze       = mem_busy;
    assign flush_if_id  = ex_flush && !mem_busy;
    assign stall_if_id  = hazard && !ex_flush && !mem_busy;
    assign bubble_id_ex = stall_if_id || flush_if_id;
    assign new_v        = id_valid && id_dest_valid && !bubble_id_ex;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_v    <= '0;
            ent_load <= '0;
            ent_dest <= '0;
        end else if (!mem_busy) begin
            ent_v    <= {ent_v[NSTAGES-2:0], new_v};
            ent_load <= {ent_load[NSTAGES-2:0], id_load};
            ent_dest <= {ent_dest[(NSTAGES-1)*REG_ADDR_W-1:0], id_dest};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall_if_id && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int NS = 3;
    localparam int LS = 2;
    localparam int CW = 4;
    localparam int SW = 2;

    logic clock = 1'b0;
    logic reset;
    logic id_valid, id_src_a_used, id_src_b_used, id_dest_valid, id_load, mem_busy, ex_flush;
    logic [RW-1:0] id_src_a, id_src_b, id_dest;
    logic [DW-1:0] rf_data_a, rf_data_b, op_a, op_b;
    logic [NS*DW-1:0] stage_result;
    logic [SW-1:0] fwd_a_sel, fwd_b_sel;
    logic stall_if_id, bubble_id_ex, freeze, flush_if_id;
    logic [CW-1:0] stall_cycles;

    pipe_hazard_ctrl #(.DATA_WIDTH(DW), .REG_ADDR_W(RW), .NSTAGES(NS), .LOAD_STAGE(LS), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_src_a(id_src_a),
        .id_src_a_used(id_src_a_used), .id_src_b(id_src_b), .id_src_b_used(id_src_b_used),
        .id_dest(id_dest), .id_dest_valid(id_dest_valid), .id_load(id_load),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .stage_result(stage_result),
        .mem_busy(mem_busy), .ex_flush(ex_flush), .op_a(op_a), .op_b(op_b),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_if_id(stall_if_id),
        .bubble_id_ex(bubble_id_ex), .freeze(freeze), .flush_if_id(flush_if_id),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    typedef struct { bit v; logic [RW-1:0] dest; bit ld; } ent_t;
    typedef struct {
        bit vld; logic [RW-1:0] sa; bit au; logic [RW-1:0] sb; bit bu;
        logic [RW-1:0] d; bit dv; bit ld; bit busy; bit fl;
        int xa; int xb; bit xst; bit xbub; bit xfz; bit xfl; int xcnt;
    } vec_t;

    ent_t pipe[$];
    int m_cnt;
    int passed = 0;
    int total  = 0;
    int e_sel_a, e_sel_b;
    logic [DW-1:0] e_op_a, e_op_b;
    bit e_stall, e_bubble, e_freeze, e_flush;
    vec_t tbl[14];
    logic [NS*DW-1:0] sr_fix = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    function automatic int winner(input logic [RW-1:0] r);
        for (int i = 0; i < pipe.size(); i++)
            if (pipe[i].v && pipe[i].dest == r && r != 0) return i + 1;
        return 0;
    endfunction

    task automatic model_clear();
        ent_t e;
        e.v = 0; e.dest = '0; e.ld = 0;
        pipe.delete();
        for (int i = 0; i < NS; i++) pipe.push_back(e);
        m_cnt = 0;
    endtask

    task automatic model_eval();
        bit haz;
        e_sel_a = id_src_a_used ? winner(id_src_a) : 0;
        e_sel_b = id_src_b_used ? winner(id_src_b) : 0;
        e_op_a  = (e_sel_a == 0) ? rf_data_a : stage_result[(e_sel_a-1)*DW +: DW];
        e_op_b  = (e_sel_b == 0) ? rf_data_b : stage_result[(e_sel_b-1)*DW +: DW];
        haz = id_valid && ((e_sel_a != 0 && pipe[e_sel_a-1].ld && e_sel_a < LS) ||
                           (e_sel_b != 0 && pipe[e_sel_b-1].ld && e_sel_b < LS));
        e_freeze = mem_busy;
        e_flush  = ex_flush && !mem_busy;
        e_stall  = haz && !ex_flush && !mem_busy;
        e_bubble = e_stall || e_flush;
    endtask

    task automatic model_advance();
        ent_t e;
        if (!mem_busy) begin
            e.v = id_valid && id_dest_valid && !e_bubble;
            e.dest = id_dest;
            e.ld = id_load;
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
        if (e_stall && m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    task automatic step_begin();
        #1;
        model_eval();
        chk("op_a", op_a, e_op_a);
        chk("op_b", op_b, e_op_b);
        chk("fwd_a_sel", fwd_a_sel, e_sel_a);
        chk("fwd_b_sel", fwd_b_sel, e_sel_b);
        chk("stall_if_id", stall_if_id, e_stall);
        chk("bubble_id_ex", bubble_id_ex, e_bubble);
        chk("freeze", freeze, e_freeze);
        chk("flush_if_id", flush_if_id, e_flush);
        chk("stall_cycles", stall_cycles, m_cnt);
    endtask

    task automatic step_end();
        model_advance();
        @(negedge clock);
    endtask

    task automatic drive(input bit vld, input int sa, input bit au, input int sb, input bit bu,
                         input int d, input bit dv, input bit ld, input bit busy, input bit fl);
        id_valid = vld; id_src_a = RW'(sa); id_src_a_used = au; id_src_b = RW'(sb);
        id_src_b_used = bu; id_dest = RW'(d); id_dest_valid = dv; id_load = ld;
        mem_busy = busy; ex_flush = fl;
    endtask

    initial begin
        tbl[0]  = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0};
        tbl[1]  = '{1,0,0,0,0, 3,1,0,0,0, 0,0,0,0,0,0,0};
        tbl[2]  = '{1,3,1,0,0, 0,0,0,0,0, 1,0,0,0,0,0,0};
        tbl[3]  = '{1,0,0,0,0, 5,1,1,0,0, 0,0,0,0,0,0,0};
        tbl[4]  = '{1,0,0,5,1, 0,0,0,0,0, 0,1,1,1,0,0,0};
        tbl[5]  = '{1,0,0,5,1, 0,0,0,0,0, 0,2,0,0,0,0,1};
        tbl[6]  = '{1,0,0,0,0, 4,1,0,0,0, 0,0,0,0,0,0,1};
        tbl[7]  = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,1};
        tbl[8]  = '{1,0,0,0,0, 4,1,0,0,0, 0,0,0,0,0,0,1};
        tbl[9]  = '{1,4,1,0,0, 0,1,0,0,0, 1,0,0,0,0,0,1};
        tbl[10] = '{1,0,1,0,1, 0,0,0,0,0, 0,0,0,0,0,0,1};
        tbl[11] = '{1,0,0,0,0, 7,1,1,0,0, 0,0,0,0,0,0,1};
        tbl[12] = '{1,7,1,0,0, 0,0,0,0,1, 1,0,0,1,0,1,1};
        tbl[13] = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,1};

        reset = 1'b1;
        drive(0,0,0,0,0, 0,0,0,0,0);
        rf_data_a = 32'hAAAA_0000; rf_data_b = 32'hBBBB_0000; stage_result = sr_fix;
        model_clear();
        #1;
        chk("reset_stall", stall_if_id, 0);
        chk("reset_bubble", bubble_id_ex, 0);
        chk("reset_freeze", freeze, 0);
        chk("reset_flush", flush_if_id, 0);
        chk("reset_sel", {fwd_a_sel, fwd_b_sel}, 0);
        chk("reset_cnt", stall_cycles, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].vld, tbl[i].sa, tbl[i].au, tbl[i].sb, tbl[i].bu,
                  tbl[i].d, tbl[i].dv, tbl[i].ld, tbl[i].busy, tbl[i].fl);
            step_begin();
            chk($sformatf("tbl%0d_sel_a", i), fwd_a_sel, tbl[i].xa);
            chk($sformatf("tbl%0d_sel_b", i), fwd_b_sel, tbl[i].xb);
            chk($sformatf("tbl%0d_op_a", i), op_a,
                tbl[i].xa == 0 ? 32'hAAAA_0000 : 32'h1000_0000 + tbl[i].xa);
            chk($sformatf("tbl%0d_op_b", i), op_b,
                tbl[i].xb == 0 ? 32'hBBBB_0000 : 32'h1000_0000 + tbl[i].xb);
            chk($sformatf("tbl%0d_ctl", i), {stall_if_id, bubble_id_ex, freeze, flush_if_id},
                {tbl[i].xst, tbl[i].xbub, tbl[i].xfz, tbl[i].xfl});
            chk($sformatf("tbl%0d_cnt", i), stall_cycles, tbl[i].xcnt);
            step_end();
        end

        // Load-use hazard held off by a 3-cycle dcache wait.
        drive(1,0,0,0,0, 9,1,1,0,0);
        step_begin(); step_end();
        for (int i = 0; i < 3; i++) begin
            drive(1,9,1,0,0, 0,0,0,1,0);
            step_begin();
            chk("frz_ctl", {freeze, stall_if_id, bubble_id_ex, flush_if_id}, 4'b1000);
            chk("frz_sel", fwd_a_sel, 1);
            step_end();
        end
        drive(1,9,1,0,0, 0,0,0,0,0);
        step_begin();
        chk("frz_release_stall", {stall_if_id, bubble_id_ex, freeze}, 3'b110);
        chk("frz_release_cnt", stall_cycles, 1);
        step_end();
        step_begin();
        chk("frz_after_sel", fwd_a_sel, 2);
        chk("frz_after_stall", stall_if_id, 0);
        chk("frz_after_cnt", stall_cycles, 2);
        step_end();

        // Load reading its own dest stalls every other cycle; drive counter into saturation.
        drive(1,9,1,0,0, 9,1,1,0,0);
        for (int i = 0; i < 41; i++) begin
            step_begin(); step_end();
        end
        step_begin();
        chk("sat_stall", stall_if_id, 1);
        chk("sat_cnt_at_stall", stall_cycles, 15);
        step_end();
        step_begin();
        chk("sat_cnt_hold", stall_cycles, 15);
        step_end();

        #1;
        chk("pre_reset_stall", stall_if_id, 1);
        reset = 1'b1;
        #1;
        chk("midreset_ctl", {stall_if_id, bubble_id_ex, freeze, flush_if_id}, 0);
        chk("midreset_sel", {fwd_a_sel, fwd_b_sel}, 0);
        chk("midreset_cnt", stall_cycles, 0);
        model_clear();
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
            rf_data_a = $urandom; rf_data_b = $urandom;
            stage_result = {$urandom, $urandom, $urandom};
            step_begin(); step_end();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
